layer_mem_arbiter: RTL and testbench

Shares the single layer-memory port (cwr/crd/caddr_wr/caddr_rd/csel) between the CONV accelerator's internal requesters: L0 conv writeback, L1 max-pool reader/writer, and L2 flatten writer. Each requester issues word-wide read or write requests over a req/gnt handshake. The block arbitrates round-robin, sequences the memory-side command and returns read data with a per-requester valid pulse. It sits between the layer engines and the top-level memory pins.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/layer_mem_arbiter_rr_pick.sv | 59 +++++
 rtl/layer_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_layer_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared CONV accelerator definitions: layer-memory select codes, arbiter
// state codes and default memory geometry.
package conv_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 12;
  localparam int DW_DEF   = 20;

  localparam logic [2:0] SEL_L0_K0 = 3'd1;
  localparam logic [2:0] SEL_L0_K1 = 3'd2;
  localparam logic [2:0] SEL_L1_K0 = 3'd3;
  localparam logic [2:0] SEL_L1_K1 = 3'd4;
  localparam logic [2:0] SEL_L2    = 3'd5;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_WR      = 2'd1;
  localparam arb_state_t ST_RD      = 2'd2;
  localparam arb_state_t ST_RD_WAIT = 2'd3;

  function automatic logic sel_legal(input logic [2:0] sel);
    return (sel >= SEL_L0_K0) && (sel <= SEL_L2);
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_rr_pick.sv
// Combinational requester selector. Round-robin from ptr by default; with
// ARB_FIXED_PRIO_EN defined the lowest index always wins and ptr is ignored.
module rr_pick
  import conv_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            any,
  output logic [PW-1:0]   nxt_ptr
);

  localparam logic [NREQ-1:0] UNIT = NREQ'(1'b1);

  logic [NREQ-1:0] cand_oh_s;
  logic            hit_s;
  int              cand_s;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;
`endif

  // Scan candidates in search order; the first requesting one wins.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    any       = 1'b0;
    cand_oh_s = '0;
    hit_s     = 1'b0;
    cand_s    = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand_s = k;
`else
      cand_s = (int'(ptr) + k) % NREQ;
`endif
      cand_oh_s = UNIT << cand_s;
      hit_s     = ~any & (|(req & cand_oh_s));
      win_oh    = win_oh | ({NREQ{hit_s}} & cand_oh_s);
      win_idx   = hit_s ? PW'(cand_s) : win_idx;
      any       = any | hit_s;
    end
  end

  // Start point for the next search.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    nxt_ptr = '0;
`else
    nxt_ptr = PW'((int'(win_idx) + 1) % NREQ);
`endif
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Layer-memory port arbiter: shares one cwr/crd memory port among NREQ
// requesters. Arbitration policy is selected in rr_pick (ARB_FIXED_PRIO_EN).
module layer_mem_arbiter
  import conv_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*3-1:0] req_sel,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              sel_err,
  output logic              arb_busy,
  output logic              cwr,
  output logic [AW-1:0]     caddr_wr,
  output logic [DW-1:0]     cdata_wr,
  output logic              crd,
  output logic [AW-1:0]     caddr_rd,
  input  logic [DW-1:0]     cdata_rd,
  output logic [2:0]        csel
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] UNIT = NREQ'(1'b1);

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   w_q, w_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rd_ok_q, rd_ok_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            sel_err_q, sel_err_d;
  logic            arb_busy_q, arb_busy_d;
  logic            cwr_q, cwr_d;
  logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
  logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
  logic            crd_q, crd_d;
  logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
  logic [2:0]      csel_q, csel_d;

  logic [NREQ-1:0] win_oh_s;
  logic [PW-1:0]   win_idx_s;
  logic [PW-1:0]   nxt_ptr_s;
  logic            any_s;
  logic [AW-1:0]   addr_s;
  logic [2:0]      sel_s;
  logic [DW-1:0]   wdata_s;
  logic            we_s;
  logic            legal_s;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s),
    .any     (any_s),
    .nxt_ptr (nxt_ptr_s)
  );

  // One-hot AND-OR mux of the winning requester's command fields.
  always_comb begin
    addr_s  = '0;
    sel_s   = 3'd0;
    wdata_s = '0;
    we_s    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      addr_s  = addr_s  | (req_addr[i*AW +: AW]  & {AW{win_oh_s[i]}});
      sel_s   = sel_s   | (req_sel[i*3 +: 3]     & {3{win_oh_s[i]}});
      wdata_s = wdata_s | (req_wdata[i*DW +: DW] & {DW{win_oh_s[i]}});
      we_s    = we_s    | (req_we[i] & win_oh_s[i]);
    end
    legal_s = sel_legal(sel_s);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    ptr_d      = ptr_q;
    rd_ok_d    = rd_ok_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    sel_err_d  = 1'b0;
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    csel_d     = 3'd0;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    caddr_rd_d = caddr_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          // Illegal selects are still granted so the requester never stalls.
          state_d   = we_s ? ST_WR : ST_RD;
          gnt_d     = win_oh_s;
          w_d       = win_idx_s;
          ptr_d     = nxt_ptr_s;
          rd_ok_d   = legal_s;
          sel_err_d = ~legal_s;
          csel_d    = legal_s ? sel_s : 3'd0;
          if (we_s) begin
            cwr_d      = legal_s;
            caddr_wr_d = addr_s;
            cdata_wr_d = wdata_s;
          end else begin
            crd_d      = legal_s;
            caddr_rd_d = addr_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        state_d  = ST_IDLE;
        rvalid_d = UNIT << w_q;
        rdata_d  = rd_ok_q ? cdata_rd : '0;
      end
      default:    state_d = ST_IDLE;
    endcase
    arb_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      ptr_q      <= '0;
      rd_ok_q    <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      sel_err_q  <= 1'b0;
      arb_busy_q <= 1'b0;
      cwr_q      <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
      csel_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      ptr_q      <= ptr_d;
      rd_ok_q    <= rd_ok_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      sel_err_q  <= sel_err_d;
      arb_busy_q <= arb_busy_d;
      cwr_q      <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      crd_q      <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      csel_q     <= csel_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign sel_err  = sel_err_q;
  assign arb_busy = arb_busy_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign csel     = csel_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench for layer_mem_arbiter: transaction-level model compared every cycle,
// plus directed literal checks. Honours ARB_FIXED_PRIO_EN like the design.
module tb_layer_mem_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int DW   = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*3-1:0] req_sel = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata, cdata_wr, cdata_rd;
  logic              sel_err, arb_busy, cwr, crd;
  logic [AW-1:0]     caddr_wr, caddr_rd;
  logic [2:0]        csel;

  int vectors = 0;
  int miscompares = 0;

  layer_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_sel(req_sel), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .sel_err(sel_err), .arb_busy(arb_busy), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [NREQ-1:0] e_gnt = '0, e_rvalid = '0;
  logic [DW-1:0]   e_rdata = '0, e_cdata_wr = '0;
  logic [AW-1:0]   e_caddr_wr = '0, e_caddr_rd = '0;
  logic            e_sel_err = 1'b0, e_busy = 1'b0, e_cwr = 1'b0, e_crd = 1'b0;
  logic [2:0]      e_csel = 3'd0;

  initial begin
    int n, next_arb, m_ptr, w, c, rd_at, rd_w;
    bit rd_pend, rd_ok, ok;
    logic [2:0] s;
    n = 0; next_arb = 0; m_ptr = 0; rd_pend = 0; rd_at = 0; rd_w = 0; rd_ok = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_cdata_wr = '0;
        e_caddr_wr = '0; e_caddr_rd = '0; e_sel_err = 1'b0; e_busy = 1'b0;
        e_cwr = 1'b0; e_crd = 1'b0; e_csel = 3'd0;
        next_arb = 0; m_ptr = 0; rd_pend = 0;
      end else begin
        e_gnt = '0; e_rvalid = '0; e_cwr = 1'b0; e_crd = 1'b0;
        e_csel = 3'd0; e_sel_err = 1'b0;
        if (rd_pend && n == rd_at) begin
          e_rvalid = NREQ'(1) << rd_w;
          e_rdata  = rd_ok ? cdata_rd : '0;
          rd_pend  = 0;
        end
        if (n >= next_arb && req != '0) begin
          w = -1;
          for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            c = k;
`else
            c = (m_ptr + k) % NREQ;
`endif
            if (w < 0 && ((req >> c) & NREQ'(1)) != '0) w = c;
          end
          s  = req_sel[w*3 +: 3];
          ok = (s >= 3'd1 && s <= 3'd5);
          e_gnt     = NREQ'(1) << w;
          e_sel_err = !ok;
          e_csel    = ok ? s : 3'd0;
          if (((req_we >> w) & NREQ'(1)) != '0) begin
            e_cwr      = ok;
            e_caddr_wr = req_addr[w*AW +: AW];
            e_cdata_wr = req_wdata[w*DW +: DW];
            next_arb   = n + 2;
          end else begin
            e_crd      = ok;
            e_caddr_rd = req_addr[w*AW +: AW];
            next_arb   = n + 3;
            rd_pend = 1; rd_at = n + 2; rd_w = w; rd_ok = ok;
          end
`ifdef ARB_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (w + 1) % NREQ;
`endif
        end
        e_busy = (n < next_arb - 1);
      end
      n++;
      #1;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("rdata", 32'(rdata), 32'(e_rdata));
      chk("sel_err", 32'(sel_err), 32'(e_sel_err));
      chk("arb_busy", 32'(arb_busy), 32'(e_busy));
      chk("cwr", 32'(cwr), 32'(e_cwr));
      chk("caddr_wr", 32'(caddr_wr), 32'(e_caddr_wr));
      chk("cdata_wr", 32'(cdata_wr), 32'(e_cdata_wr));
      chk("crd", 32'(crd), 32'(e_crd));
      chk("caddr_rd", 32'(caddr_rd), 32'(e_caddr_rd));
      chk("csel", 32'(csel), 32'(e_csel));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [2:0] s, input logic [DW-1:0] d);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_sel[i*3 +: 3]      = s;
    req_wdata[i*DW +: DW]  = d;
    req[i]                 = 1'b1;
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] ord [8];

  initial begin
    cdata_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_csel", 32'(csel), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single write
    set_req(0, 1'b1, 12'h041, 3'd1, 20'h0ABCD);
    tick_check();
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_cwr", 32'(cwr), 32'h1);
    chk("wr_caddr", 32'(caddr_wr), 32'h041);
    chk("wr_csel", 32'(csel), 32'h1);
    chk("wr_cdata", 32'(cdata_wr), 32'h0ABCD);
    @(negedge clk); req = '0;
    tick_check();
    chk("wr_csel_off", 32'(csel), 32'h0);
    @(negedge clk);

    // single read
    cdata_rd = 20'h12345;
    set_req(2, 1'b0, 12'h3FF, 3'd5, 20'h0);
    tick_check();
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_crd", 32'(crd), 32'h1);
    chk("rd_caddr", 32'(caddr_rd), 32'h3FF);
    @(negedge clk); req = '0;
    tick_check();
    chk("rd_rvalid_early", 32'(rvalid), 32'h0);
    tick_check();
    chk("rd_rvalid", 32'(rvalid), 32'h4);
    chk("rd_rdata", 32'(rdata), 32'h12345);
    @(negedge clk);

    // contention, all writes
`ifdef ARB_FIXED_PRIO_EN
    ord = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
`else
    ord = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
`endif
    set_req(0, 1'b1, 12'h010, 3'd1, 20'h00001);
    set_req(1, 1'b1, 12'h020, 3'd2, 20'h00002);
    set_req(2, 1'b1, 12'h030, 3'd3, 20'h00003);
    for (int i = 0; i < 8; i++) begin
      tick_check();
      chk("cont_gnt", 32'(gnt), 32'(ord[i]));
    end
    @(negedge clk); req = '0;
    repeat (2) @(negedge clk);

    // illegal select, write
    set_req(1, 1'b1, 12'h555, 3'd7, 20'hAAAAA);
    tick_check();
    chk("ill_gnt", 32'(gnt), 32'h2);
    chk("ill_sel_err", 32'(sel_err), 32'h1);
    chk("ill_cwr", 32'(cwr), 32'h0);
    chk("ill_csel", 32'(csel), 32'h0);
    @(negedge clk); req = '0;
    tick_check();
    chk("ill_sel_err_off", 32'(sel_err), 32'h0);
    @(negedge clk);

    // illegal select, read: rvalid still pulses with zero data
    cdata_rd = 20'hFFFFF;
    set_req(0, 1'b0, 12'h001, 3'd0, 20'h0);
    tick_check();
    chk("illr_gnt", 32'(gnt), 32'h1);
    chk("illr_crd", 32'(crd), 32'h0);
    @(negedge clk); req = '0;
    tick_check();
    tick_check();
    chk("illr_rvalid", 32'(rvalid), 32'h1);
    chk("illr_rdata", 32'(rdata), 32'h0);
    @(negedge clk);

    // reset during RD_WAIT
    cdata_rd = 20'h55555;
    set_req(1, 1'b0, 12'h123, 3'd3, 20'h0);
    tick_check();
    chk("rr_crd", 32'(crd), 32'h1);
    @(negedge clk); req = '0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(arb_busy), 32'h0);
    chk("rst_mid_caddr_rd", 32'(caddr_rd), 32'h0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    set_req(1, 1'b1, 12'h0AA, 3'd2, 20'h11111);
    set_req(2, 1'b1, 12'h0BB, 3'd4, 20'h22222);
    tick_check();
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk); req = '0;
    repeat (4) tick_check();
    chk("post_rst_rvalid_late", 32'(rvalid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
